// File: rtl/bit_right_shift_16.sv
// 16-bit logical right barrel shifter, out = (b >= 16) ? 0 : a >> b; one cycle latency.
// No backpressure: a new operand pair is accepted on every cycle that in_valid is high.
module bit_right_shift_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int STAGES = 4;

    logic [WIDTH-1:0] stage [0:STAGES];
    logic             over_range;
    logic [WIDTH-1:0] result;

    assign stage[0] = a;

    // Stage k conditionally shifts by 2^k under control of b[k].
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign stage[k+1] = b[k] ? (stage[k] >> SH) : stage[k];
    end

    // Any upper shift bit set moves every bit out of the word.
    assign over_range = |b[WIDTH-1:STAGES];
    assign result     = over_range ? '0 : stage[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= result;
            end
        end
    end

endmodule

// File: tb/tb_bit_right_shift_16.sv
// Scoreboard bench for bit_right_shift_16: driver queues expected results, monitor checks on each falling edge.
module tb_bit_right_shift_16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        out_valid;

    int          checks;
    int          errors;
    logic [15:0] exp_q [$];
    logic [15:0] last_out;

    bit_right_shift_16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [15:0] s);
        return (s >= 16'd16) ? 16'h0000 : (x >> s[3:0]);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Inputs change 2 time units after a rising edge; the next rising edge samples them.
    task automatic step(input logic v, input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] e);
        @(posedge clk);
        #2;
        in_valid = v;
        a        = ta;
        b        = tb_;
        if (v && rst_n) exp_q.push_back(e);
    endtask

    // Monitor: falling-edge sampling, decoupled from stimulus.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_out", out, 16'h0000);
            check("reset_valid", {15'd0, out_valid}, 16'h0000);
            last_out = 16'h0000;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: out_valid=1 out=%h, expected no result", out);
            end else begin
                check("result", out, exp_q.pop_front());
                last_out = out;
            end
        end else begin
            check("hold", out, last_out);
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        last_out = 16'h0000;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 16'h0007;
        b        = 16'h0002;

        // Reset held with valid inputs present; monitor checks zeros each cycle.
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        exp_q.push_back(16'h0001);

        step(1'b1, 16'h0007, 16'd2,  16'h0001);
        step(1'b1, 16'h0007, 16'd1,  16'h0003);
        step(1'b1, 16'h000F, 16'd1,  16'h0007);
        step(1'b1, 16'h003F, 16'd5,  16'h0001);
        step(1'b1, 16'hFFFF, 16'd0,  16'hFFFF);
        step(1'b1, 16'hFFFF, 16'd15, 16'h0001);
        step(1'b1, 16'h8000, 16'd15, 16'h0001);
        step(1'b1, 16'hFFFF, 16'd16, 16'h0000);
        step(1'b1, 16'hFFFF, 16'h0100, 16'h0000);
        step(1'b1, 16'h00F0, 16'd4,  16'h000F);

        // Idle with changing operands: out must hold 000F.
        step(1'b0, 16'hFFFF, 16'd0,  16'h0000);
        step(1'b0, 16'h1234, 16'd3,  16'h0000);
        step(1'b0, 16'hABCD, 16'd20, 16'h0000);
        check("hold_value", out, 16'h000F);

        // Mid-stream reset right after the accepting edge discards the result.
        step(1'b1, 16'h1234, 16'd4,  16'h0123);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        in_valid = 1'b0;
        #1;
        check("async_reset_out", out, 16'h0000);
        check("async_reset_valid", {15'd0, out_valid}, 16'h0000);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) step(1'b0, 16'h5555, 16'd1, 16'h0000);

        // Random operands, shift amount biased to 0..20.
        for (int i = 0; i < 1000; i++) begin
            logic        rv;
            logic [15:0] ra;
            logic [15:0] rb;
            rv = 1'($urandom_range(0, 3) != 0);
            ra = 16'($urandom);
            if ($urandom_range(0, 9) == 0) rb = 16'($urandom);
            else                           rb = 16'($urandom_range(0, 20));
            step(rv, ra, rb, ref_shift(ra, rb));
        end

        step(1'b0, 16'h0000, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_right_shift_16.md
Name: bit_right_shift_16

Overview:
- 16-bit logical right shifter used by the datapath's bitwise/shift unit.
- Shifts operand a right by the amount on b.
- Built as a log-structured barrel shifter (stages of 1/2/4/8) with a registered output.
- Latency is one clock; a simple valid flag travels alongside the data.

Parameters:
- WIDTH, 16, data width of a, b and out. Only 16 is supported; the shift stages are sized for 16.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a/b are sampled this cycle when high.
- a  input  16  operand to be shifted (unsigned).
- b  input  16  shift amount (unsigned, full 16-bit value significant).
- out  output  16  registered result a >> b.
- out_valid  output  1  high for exactly one cycle per accepted input, aligned with out.

Behaviour:
- Reset:
  - rst_n low asynchronously forces out = 16'h0000 and out_valid = 0 immediately, independent of clk.
  - Both stay at these values while rst_n is low.
  - Release is synchronous in effect: the first capture happens on the first rising clk edge with rst_n high.
- Shift function:
  - Logical right shift: vacated MSBs are filled with 0. There is no sign extension.
  - Bits shifted past bit 0 are discarded.
- Shift-amount rules:
  - b[3:0] drives four cascaded stages. Stage k shifts by 2^k when b[k] = 1, otherwise it passes its input through.
  - If any of b[15:4] is nonzero (b >= 16), the result is 16'h0000 regardless of a.
  - b = 0 gives out = a.
- Timing:
  - On each rising clk edge with in_valid = 1, out <= shift(a, b) and out_valid <= 1.
  - On a rising edge with in_valid = 0, out holds its previous value and out_valid <= 0.
- Latency and throughput:
  - Exactly 1 cycle from the sampling edge to a valid out.
  - Full throughput: a new operation is accepted every cycle.
  - No backpressure and no ready signal.
- Back-to-back inputs: each result appears on the cycle after its input, in order, with no bubbles.
- Reset mid-operation:
  - Asserting rst_n during or just after an accepted input discards that result.
  - out_valid is not raised for the discarded input after reset is released.
- X handling: a or b containing X while in_valid = 0 must not change out.
- The combinational path from a/b to the output register contains no latches.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1, a = 16'h0007, b = 16'h0002, and toggle clk -> out = 16'h0000 and out_valid = 0 throughout. Release and clock once -> out = 16'h0001, out_valid = 1.
- Directed vectors, one per cycle with in_valid = 1, each appearing one cycle after its input with out_valid = 1:
  - a = 16'h0007, b = 2 -> out = 16'h0001.
  - a = 16'h0007, b = 1 -> out = 16'h0003.
  - a = 16'h000F, b = 1 -> out = 16'h0007.
  - a = 16'h003F, b = 5 -> out = 16'h0001.
- Boundaries:
  - a = 16'hFFFF, b = 0 -> out = 16'hFFFF.
  - a = 16'hFFFF, b = 15 -> out = 16'h0001.
  - a = 16'h8000, b = 15 -> out = 16'h0001 (no sign fill).
  - a = 16'hFFFF, b = 16 -> out = 16'h0000.
  - a = 16'hFFFF, b = 16'h0100 -> out = 16'h0000.
- Hold: present a = 16'h00F0, b = 4 -> out = 16'h000F. Then drop in_valid and change a/b -> out stays 16'h000F and out_valid = 0 on following cycles.
- Mid-stream reset: accept a = 16'h1234, b = 4, then pulse rst_n low between clock edges -> out = 0 and out_valid = 0 immediately; no out_valid pulse for the discarded input after release.
- Random: 1000 random a/b pairs (b biased to 0..20) with random in_valid, compared against a reference model (b >= 16 ? 0 : a >> b) with 1-cycle delay.
